// File: rtl/imem_pkg.sv
// Shared parameters and state encoding for the instruction-memory load controller.
package imem_pkg;

    localparam int IW_DEF         = 19;
    localparam int DEPTH_DEF      = 128;
    localparam int PCW_DEF        = 32;
    localparam int RELEASE_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // Limit a host-requested word count to what the memory can hold.
    function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction memory: one synchronous write port, one asynchronous read port, no reset.
module imem_ram
    import imem_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [IW-1:0]            i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [IW-1:0]            o_rdata
);

    logic [IW-1:0] r_mem [DEPTH];

    // Write port; contents survive reset so an aborted load keeps what it wrote.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_load_ctrl.sv
// Host-driven program loader: fills the instruction memory, then releases the CPU.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a load request, CPU held in reset
// ST_LOAD    | accepting host words, CPU held in reset
// ST_RELEASE | last word written, CPU kept in reset for RELEASE_CYCLES
// ST_RUN     | CPU running, fetches served from memory
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int PCW   = PCW_DEF
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           LD_START,
    input  logic [7:0]     LD_LEN,
    input  logic           LD_VALID,
    input  logic [IW-1:0]  LD_DATA,
    output logic           LD_READY,
    output logic           LD_DONE,
    input  logic [PCW-1:0] PC,
    output logic [IW-1:0]  INSTRUCTION,
    output logic           CPU_RESET,
    output logic           FETCH_ERR
);

    localparam int AW = $clog2(DEPTH);
    // LD_LEN is 8 bits, so a length never exceeds 255 even for deeper memories.
    localparam logic [7:0] LEN_MAX  = (DEPTH > 255) ? 8'd255 : 8'(DEPTH);
    localparam logic [1:0] REL_LOAD = 2'(RELEASE_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_remain;
    logic [1:0]    r_rel_cnt;
    logic          r_ld_ready;
    logic          r_ld_done;
    logic          r_cpu_reset;
    logic          r_fetch_err;
    logic          w_start;
    logic          w_load_entry;
    logic          w_we;
    logic          w_last;
    logic          w_pc_in_range;
    logic [IW-1:0] w_rdata;

    assign w_start       = LD_START && (LD_LEN != 8'd0);
    assign w_we          = r_ld_ready && LD_VALID;
    assign w_last        = w_we && (r_remain == 8'd1);
    assign w_pc_in_range = (PC < PCW'(DEPTH));

    // Next-state decode; LD_START is only honoured from IDLE or RUN.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_entry = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt  = ST_LOAD;
                    w_load_entry = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_last) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (r_rel_cnt == 2'd0) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_start) begin
                    w_state_nxt  = ST_LOAD;
                    w_load_entry = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and registered outputs, all derived from the next state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_IDLE;
            r_ld_ready  <= 1'b0;
            r_ld_done   <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_fetch_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ld_ready  <= (w_state_nxt == ST_LOAD);
            r_ld_done   <= w_last;
            r_cpu_reset <= (w_state_nxt != ST_RUN);
            if (w_load_entry) begin
                r_fetch_err <= 1'b0;
            end else if ((r_state == ST_RUN) && !w_pc_in_range) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    // Write address, remaining-word down-counter and release timer.
    // The address holds on the final write so a full-depth load never wraps to 0.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_addr    <= '0;
            r_remain  <= 8'd0;
            r_rel_cnt <= 2'd0;
        end else begin
            if (w_load_entry) begin
                r_addr   <= '0;
                r_remain <= clamp_len(LD_LEN, LEN_MAX);
            end else if (w_we) begin
                r_remain <= r_remain - 8'd1;
                if (!w_last) begin
                    r_addr <= r_addr + AW'(1);
                end
            end
            if (w_last) begin
                r_rel_cnt <= REL_LOAD;
            end else if ((r_state == ST_RELEASE) && (r_rel_cnt != 2'd0)) begin
                r_rel_cnt <= r_rel_cnt - 2'd1;
            end
        end
    end

    imem_ram #(
        .IW    (IW),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (CLK),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (LD_DATA),
        .i_raddr (PC[AW-1:0]),
        .o_rdata (w_rdata)
    );

    assign INSTRUCTION = ((r_state == ST_RUN) && w_pc_in_range) ? w_rdata : '0;
    assign LD_READY    = r_ld_ready;
    assign LD_DONE     = r_ld_done;
    assign CPU_RESET   = r_cpu_reset;
    assign FETCH_ERR   = r_fetch_err;

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter IW, default 19, instruction width in bits.
REQ-002 SHALL have parameter DEPTH, default 128, instruction memory words (power of two).
REQ-003 SHALL have parameter PCW, default 32, CPU program-counter width.
REQ-004 SHALL have port CLK  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port LD_START  input  1  host request to begin a program load.
REQ-007 SHALL have port LD_LEN  input  8  words to load, sampled with LD_START.
REQ-008 SHALL have port LD_VALID  input  1  host word valid.
REQ-009 SHALL have port LD_DATA  input  IW  host instruction word.
REQ-010 SHALL have port LD_READY  output  1  controller accepts word this cycle.
REQ-011 SHALL have port LD_DONE  output  1  one-cycle pulse when the last word is written.
REQ-012 SHALL have port PC  input  PCW  CPU fetch address (word index).
REQ-013 SHALL have port INSTRUCTION  output  IW  fetched instruction to CPU.
REQ-014 SHALL have port CPU_RESET  output  1  active-high reset driven into the CPU.
REQ-015 SHALL have port FETCH_ERR  output  1  sticky flag, PC outside memory.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RELEASE, RUN.
REQ-017 SHALL, in IDLE, hold CPU_RESET=1, LD_READY=0; LD_START with LD_LEN!=0 moves to LOAD.
REQ-018 SHALL ignore LD_START when LD_LEN==0 and clamp LD_LEN>DEPTH to DEPTH.
REQ-019 SHALL, on entering LOAD, clear write address to 0, latch length, clear FETCH_ERR.
REQ-020 SHALL, in LOAD, assert LD_READY=1 and CPU_RESET=1; word written when LD_VALID&&LD_READY, address then increments.
REQ-021 SHALL write the final word, pulse LD_DONE for exactly that cycle, and go to RELEASE next cycle.
REQ-022 SHALL hold CPU_RESET=1 in RELEASE for exactly 2 cycles, then go to RUN with CPU_RESET=0.
REQ-023 SHALL, in RUN, drive INSTRUCTION = mem[PC] combinationally (zero-cycle read latency) when PC<DEPTH.
REQ-024 SHALL, in RUN, drive INSTRUCTION=0 and set FETCH_ERR=1 (at next edge) when PC>=DEPTH.
REQ-025 SHALL drive INSTRUCTION=0 in IDLE, LOAD and RELEASE.
REQ-026 SHALL, on LD_START in RUN, move to LOAD and reassert CPU_RESET in the same cycle's registered output (next edge).
REQ-027 SHALL ignore LD_START while in LOAD or RELEASE.
REQ-028 SHALL leave memory words beyond the loaded length unchanged.
REQ-029 SHALL write the word at the maximum address DEPTH-1 without overflow; the address counter SHALL NOT wrap into address 0 during one load.

Reset
REQ-030 SHALL, on RESET=0, immediately enter IDLE with CPU_RESET=1, LD_READY=0, LD_DONE=0, FETCH_ERR=0, address=0.
REQ-031 SHALL abort any load in progress on reset; memory contents are not cleared.
REQ-032 SHALL leave IDLE only on LD_START after RESET returns to 1.

Structure
REQ-033 SHALL place IW, DEPTH, PCW defaults and the FSM state encoding in shared package imem_pkg.
REQ-034 SHALL instantiate sub-module imem_ram (DEPTH x IW, one synchronous write port, one asynchronous read port).
REQ-035 SHALL register all outputs except INSTRUCTION.

Verification
REQ-036 SHALL load 7 words (LD_LEN=7: 19'b1000000100000000010 ... 19'b1000001010000001010) -> LD_DONE pulses once on the 7th write; CPU_RESET falls 2 cycles later; INSTRUCTION at PC=2 equals 19'b0000000010001000011.
REQ-037 SHALL deassert LD_VALID for 3 cycles mid-load -> no writes, address holds, load completes with correct contents.
REQ-038 SHALL drive PC=128 in RUN -> INSTRUCTION=0, FETCH_ERR=1 and stays 1 until next LD_START.
REQ-039 SHALL pulse RESET=0 after 4 of 7 words -> IDLE, CPU_RESET=1, LD_READY=0 immediately; words 0-3 retained.
REQ-040 SHALL issue LD_LEN=0 then LD_LEN=200 -> first ignored; second loads exactly 128 words, last at address 127.
REQ-041 SHALL issue LD_START in RUN -> CPU_RESET=1 at next edge, state LOAD, address 0.
